// File: rtl/mem_pkg.sv
// Shared data-memory definitions: size-select encodings and the arbiter state type.
package mem_pkg;

    localparam logic [2:0] MEM_SZ_B  = 3'b000;
    localparam logic [2:0] MEM_SZ_H  = 3'b001;
    localparam logic [2:0] MEM_SZ_W  = 3'b010;
    localparam logic [2:0] MEM_SZ_BU = 3'b100;
    localparam logic [2:0] MEM_SZ_HU = 3'b101;

    localparam int STARVE_CNT_W = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter with clear; o_hit flags the increment that would reach LIMIT,
// and that increment wraps the count back to zero instead of storing LIMIT.
module starve_counter
    import mem_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    logic [STARVE_CNT_W-1:0] r_cnt;
    logic [STARVE_CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign o_hit     = i_inc && (w_cnt_inc == LIMIT[STARVE_CNT_W-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_hit) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the shared data-memory port, with a starvation-driven
// one-cycle FORCE grant for the external valid/ready requester.
//   state     | meaning
//   ARB_IDLE  | core has priority, external granted only when core is quiet
//   ARB_FORCE | single stall cycle, external granted unconditionally
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_core_req,
    input  logic [31:0] i_core_addr,
    input  logic        i_core_w,
    input  logic [2:0]  i_core_w_sel,
    input  logic [31:0] i_core_wdata,
    output logic [31:0] o_core_rdata,
    output logic        o_core_stall,
    input  logic        i_ext_valid,
    output logic        o_ext_ready,
    input  logic [31:0] i_ext_addr,
    input  logic        i_ext_w,
    input  logic [2:0]  i_ext_w_sel,
    input  logic [31:0] i_ext_wdata,
    output logic        o_ext_rvalid,
    output logic [31:0] o_ext_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_w,
    output logic [2:0]  o_mem_w_sel,
    output logic [31:0] o_mem_in_data,
    input  logic [31:0] i_mem_out_data,
    output logic        o_proto_err
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_rd_pend;
    logic       r_proto_err;
    logic       w_ext_hs;
    logic       w_core_gnt;
    logic       w_starve_inc;
    logic       w_starve_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ARB_IDLE;
            r_rd_pend   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_ext_hs & ~i_ext_w;
            if ((r_state == ARB_FORCE) && i_core_req) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = ARB_IDLE;
        o_ext_ready  = 1'b0;
        o_core_stall = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ARB_IDLE: begin
                    o_ext_ready = i_ext_valid & ~i_core_req;
                    if (w_starve_hit) begin
                        w_state_nxt = ARB_FORCE;
                    end
                end
                ARB_FORCE: begin
                    o_ext_ready  = i_ext_valid;
                    o_core_stall = 1'b1;
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    assign w_ext_hs     = o_ext_ready;
    assign w_core_gnt   = ~i_rst & i_core_req & (r_state == ARB_IDLE);
    assign w_starve_inc = ~i_rst & (r_state == ARB_IDLE) & i_ext_valid & ~o_ext_ready;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_ext_hs | ~i_ext_valid),
        .i_inc (w_starve_inc),
        .o_hit (w_starve_hit)
    );

    // Grants are mutually exclusive: an IDLE handshake requires core_req low.
    always_comb begin
        o_mem_addr    = '0;
        o_mem_w       = 1'b0;
        o_mem_w_sel   = '0;
        o_mem_in_data = '0;
        if (w_core_gnt) begin
            o_mem_addr    = i_core_addr;
            o_mem_w       = i_core_w;
            o_mem_w_sel   = i_core_w_sel;
            o_mem_in_data = i_core_wdata;
        end else if (w_ext_hs) begin
            o_mem_addr    = i_ext_addr;
            o_mem_w       = i_ext_w;
            o_mem_w_sel   = i_ext_w_sel;
            o_mem_in_data = i_ext_wdata;
        end
    end

    assign o_core_rdata = i_mem_out_data;
    assign o_ext_rvalid = r_rd_pend & ~i_rst;
    assign o_ext_rdata  = o_ext_rvalid ? i_mem_out_data : 32'd0;
    assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle grant/mux behaviour
// plus sequences for reset, read latency, starvation, collision and interleave.
module tb_dmem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_w, ext_valid, ext_w;
    logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
    logic [2:0]  core_w_sel, ext_w_sel;
    logic [31:0] core_rdata, ext_rdata, mem_addr, mem_in_data;
    logic        core_stall, ext_ready, ext_rvalid, mem_w, proto_err;
    logic [2:0]  mem_w_sel;
    logic [31:0] mem_out_data = 32'd0;
    logic [31:0] mem_model [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_addr(core_addr), .i_core_w(core_w),
        .i_core_w_sel(core_w_sel), .i_core_wdata(core_wdata),
        .o_core_rdata(core_rdata), .o_core_stall(core_stall),
        .i_ext_valid(ext_valid), .o_ext_ready(ext_ready), .i_ext_addr(ext_addr),
        .i_ext_w(ext_w), .i_ext_w_sel(ext_w_sel), .i_ext_wdata(ext_wdata),
        .o_ext_rvalid(ext_rvalid), .o_ext_rdata(ext_rdata),
        .o_mem_addr(mem_addr), .o_mem_w(mem_w), .o_mem_w_sel(mem_w_sel),
        .o_mem_in_data(mem_in_data), .i_mem_out_data(mem_out_data),
        .o_proto_err(proto_err)
    );

    // Synchronous memory: write on mem_w, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_w) mem_model[mem_addr[9:2]] <= mem_in_data;
        mem_out_data <= mem_model[mem_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet();
        core_req = 0; core_w = 0; core_addr = 0; core_wdata = 0; core_w_sel = MEM_SZ_W;
        ext_valid = 0; ext_w = 0; ext_addr = 0; ext_wdata = 0; ext_w_sel = MEM_SZ_W;
    endtask

    task automatic do_reset();
        @(negedge clk); quiet(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    typedef struct {
        logic        core_req;
        logic        core_w;
        logic [31:0] core_addr;
        logic        ext_valid;
        logic        ext_w;
        logic [31:0] ext_addr;
        logic        exp_ready;
        logic        exp_mem_w;
        logic [31:0] exp_addr;
        logic [1:0]  exp_gnt;   // 0 none, 1 core, 2 ext
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_wd;
        logic [2:0]  exp_sel;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h80, 1'b0, 1'b0, 32'h00, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 32'h10, 2'd1};
        vecs[2] = '{1'b1, 1'b0, 32'h14, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h14, 2'd1};
        vecs[3] = '{1'b0, 1'b0, 32'h14, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 2'd2};
        vecs[4] = '{1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h84, 1'b1, 1'b0, 32'h84, 2'd2};
        vecs[5] = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b0, 32'h88, 1'b0, 1'b1, 32'h18, 2'd1};
        vecs[6] = '{1'b0, 1'b0, 32'h18, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0, 32'h00, 2'd0};

        // Reset behaviour: outputs held low while rst is high even with a request present.
        quiet(); rst = 1;
        @(negedge clk); ext_valid = 1; core_req = 1;
        #1;
        check("rst_ext_ready", {31'd0, ext_ready}, 32'd0);
        check("rst_core_stall", {31'd0, core_stall}, 32'd0);
        check("rst_mem_w", {31'd0, mem_w}, 32'd0);
        check("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        do_reset();

        // Single-cycle grant and port mux vectors.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            quiet();
            core_req = vecs[i].core_req; core_w = vecs[i].core_w; core_addr = vecs[i].core_addr;
            core_wdata = 32'h1111_0000 + i; core_w_sel = MEM_SZ_H;
            ext_valid = vecs[i].ext_valid; ext_w = vecs[i].ext_w; ext_addr = vecs[i].ext_addr;
            ext_wdata = 32'h2222_0000 + i; ext_w_sel = MEM_SZ_BU;
            exp_wd  = (vecs[i].exp_gnt == 2'd1) ? 32'h1111_0000 + i :
                      (vecs[i].exp_gnt == 2'd2) ? 32'h2222_0000 + i : 32'd0;
            exp_sel = (vecs[i].exp_gnt == 2'd1) ? MEM_SZ_H :
                      (vecs[i].exp_gnt == 2'd2) ? MEM_SZ_BU : 3'b000;
            #1;
            check($sformatf("vec%0d_ext_ready", i), {31'd0, ext_ready}, {31'd0, vecs[i].exp_ready});
            check($sformatf("vec%0d_mem_w", i), {31'd0, mem_w}, {31'd0, vecs[i].exp_mem_w});
            check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_mem_in_data", i), mem_in_data, exp_wd);
            check($sformatf("vec%0d_mem_w_sel", i), {29'd0, mem_w_sel}, {29'd0, exp_sel});
            check($sformatf("vec%0d_core_stall", i), {31'd0, core_stall}, 32'd0);
        end

        // Reset mid-read discards the in-flight read.
        do_reset();
        @(negedge clk); ext_valid = 1; ext_w = 0; ext_addr = 32'h40;
        #1; check("midrd_ready", {31'd0, ext_ready}, 32'd1);
        @(negedge clk); quiet(); rst = 1;
        #1; check("midrd_rvalid", {31'd0, ext_rvalid}, 32'd0);
        check("midrd_proto_err", {31'd0, proto_err}, 32'd0);
        @(negedge clk); rst = 0;

        // Free-port write then read-back.
        @(negedge clk); quiet(); ext_valid = 1; ext_w = 1; ext_addr = 32'h100; ext_wdata = 32'hDEADBEEF;
        #1; check("wr_mem_w", {31'd0, mem_w}, 32'd1);
        check("wr_mem_addr", mem_addr, 32'h100);
        check("wr_mem_data", mem_in_data, 32'hDEADBEEF);
        @(negedge clk); ext_w = 0; ext_wdata = 0;
        #1; check("rd_ready", {31'd0, ext_ready}, 32'd1);
        check("rd_rvalid_early", {31'd0, ext_rvalid}, 32'd0);
        @(negedge clk); quiet();
        #1; check("rd_rvalid", {31'd0, ext_rvalid}, 32'd1);
        check("rd_rdata", ext_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1; check("rd_rvalid_drop", {31'd0, ext_rvalid}, 32'd0);
        check("rd_rdata_zero", ext_rdata, 32'd0);

        // Starvation with core busy every cycle; core_req stays high into FORCE (violation).
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); quiet();
            core_req = 1; core_addr = 32'h200;
            ext_valid = (c <= 8); ext_w = 1; ext_addr = 32'h300; ext_wdata = 32'h5A5A_0000;
            #1;
            check($sformatf("starve_c%0d_stall", c), {31'd0, core_stall}, (c == 8) ? 32'd1 : 32'd0);
            check($sformatf("starve_c%0d_ready", c), {31'd0, ext_ready}, (c == 8) ? 32'd1 : 32'd0);
            check($sformatf("starve_c%0d_addr", c), mem_addr, (c == 8) ? 32'h300 : 32'h200);
            check($sformatf("starve_c%0d_proto", c), {31'd0, proto_err}, (c == 9) ? 32'd1 : 32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); quiet();
            #1; check("proto_sticky", {31'd0, proto_err}, 32'd1);
        end
        do_reset();
        #1; check("proto_cleared", {31'd0, proto_err}, 32'd0);

        // Collision: core drops in cycle 7, handshake wins and no FORCE follows.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); quiet();
            core_req = (c != 7); core_addr = 32'h204;
            ext_valid = (c <= 7); ext_addr = 32'h44;
            #1;
            check($sformatf("coll_c%0d_ready", c), {31'd0, ext_ready}, (c == 7) ? 32'd1 : 32'd0);
            check($sformatf("coll_c%0d_stall", c), {31'd0, core_stall}, 32'd0);
        end
        // Counter restarted from zero: next blocked run forces exactly at cycle 8.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); quiet();
            core_req = (c != 8); ext_valid = 1; ext_addr = 32'h48;
            #1;
            check($sformatf("coll2_c%0d_stall", c), {31'd0, core_stall}, (c == 8) ? 32'd1 : 32'd0);
        end
        @(negedge clk); quiet();
        #1; check("coll_no_proto", {31'd0, proto_err}, 32'd0);

        // Pipelined interleave: external read at 0x20, then core read at 0x24.
        @(negedge clk); quiet(); ext_valid = 1; ext_w = 1; ext_addr = 32'h20; ext_wdata = 32'hAAAA_0020;
        @(negedge clk); ext_addr = 32'h24; ext_wdata = 32'hBBBB_0024;
        @(negedge clk); quiet(); ext_valid = 1; ext_addr = 32'h20;
        #1; check("il_n_ready", {31'd0, ext_ready}, 32'd1);
        @(negedge clk); quiet(); core_req = 1; core_addr = 32'h24;
        #1; check("il_n1_rvalid", {31'd0, ext_rvalid}, 32'd1);
        check("il_n1_rdata", ext_rdata, 32'hAAAA_0020);
        check("il_n1_addr", mem_addr, 32'h24);
        @(negedge clk); quiet();
        #1; check("il_n2_rvalid", {31'd0, ext_rvalid}, 32'd0);
        check("il_n2_core_rdata", core_rdata, 32'hBBBB_0024);

        // Back-to-back external reads give consecutive rvalid pulses.
        @(negedge clk); quiet(); ext_valid = 1; ext_addr = 32'h24;
        @(negedge clk); ext_addr = 32'h20;
        #1; check("b2b_rvalid0", {31'd0, ext_rvalid}, 32'd1);
        check("b2b_rdata0", ext_rdata, 32'hBBBB_0024);
        @(negedge clk); quiet();
        #1; check("b2b_rvalid1", {31'd0, ext_rvalid}, 32'd1);
        check("b2b_rdata1", ext_rdata, 32'hAAAA_0020);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single data-memory port. The port is shared between the core's MEM-stage load/store path and an external requester (program loader / debug master) that uses a valid/ready handshake. The core has fixed priority. A starvation counter guarantees the external side forward progress by requesting a one-cycle core freeze. The arbiter sits between `core`'s `mem_*` outputs and the data memory.

## Interface
- `STARVE_LIMIT`, default 8: consecutive blocked external cycles that trigger a forced grant. Legal range is 2..255.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `core_req`  in  1  Core has a load or store in MEM this cycle.
- `core_addr`  in  32  Core byte address.
- `core_w`  in  1  Core write enable.
- `core_w_sel`  in  3  Core funct3 size select.
- `core_wdata`  in  32  Core store data.
- `core_rdata`  out  32  Memory read data, passed through to the core.
- `core_stall`  out  1  Core must freeze its MEM stage and hold `core_req` low this cycle.
- `ext_valid`  in  1  External request valid.
- `ext_ready`  out  1  External request accepted this cycle.
- `ext_addr`  in  32  External byte address.
- `ext_w`  in  1  External write enable.
- `ext_w_sel`  in  3  External size select.
- `ext_wdata`  in  32  External store data.
- `ext_rvalid`  out  1  External read data valid.
- `ext_rdata`  out  32  External read data.
- `mem_addr`  out  32  Memory address.
- `mem_w`  out  1  Memory write strobe.
- `mem_w_sel`  out  3  Memory size select.
- `mem_in_data`  out  32  Memory write data.
- `mem_out_data`  in  32  Memory read data, valid the cycle after its address is presented.
- `proto_err`  out  1  Sticky flag: `core_req` was seen while `core_stall` was asserted.

## Operation
- **FSM states**
  - IDLE: core has priority.
  - FORCE: one cycle in which the external requester is granted unconditionally.
- **Grant in IDLE:** `ext_ready = ext_valid & ~core_req`.
- **Grant in FORCE:** `ext_ready = ext_valid` and `core_stall = 1`.
- **Port mux**
  - The granted side drives `mem_addr`, `mem_w_sel`, `mem_in_data` and `mem_w`.
  - The core is granted when `core_req` is high and the state is IDLE; then `mem_w = core_w`.
  - The external side is granted on handshake; then `mem_w = ext_w`.
  - With no grant: `mem_w = 0` and all other `mem_*` outputs are 0.
- **Starvation counter** (8-bit `starve_cnt`)
  - Increments in IDLE when `ext_valid & ~ext_ready`.
  - Clears on any external handshake, or when `ext_valid = 0`.
  - When an increment would make it equal `STARVE_LIMIT`: `state <= FORCE` and `starve_cnt <= 0`.
- **FORCE exit:** always returns to IDLE after one cycle.
- **External read tracking:** a 1-bit register `rd_pend <= handshake & ~ext_w`.
  - `ext_rvalid = rd_pend`.
  - `ext_rdata = mem_out_data` when `rd_pend`, else 0.
- **Core read data:** `core_rdata = mem_out_data`, unconditionally.
- **External protocol:** once `ext_valid` rises, the request fields stay stable and `ext_valid` stays high until `ext_ready`. The arbiter does not check this.
- **Protocol violation:** `core_req` high in FORCE is dropped (no memory access). `proto_err` is set and held until `rst`.
- **FORCE with `ext_valid` low:** the stall cycle still occurs, with no transfer and no memory access.
- **Writes** commit at the rising edge of the cycle in which `mem_w = 1`.

## Timing
- **Reset values:** state IDLE, `starve_cnt = 0`, `rd_pend = 0`, `proto_err = 0`.
- **Outputs during reset:** `ext_ready = 0`, `core_stall = 0`, `ext_rvalid = 0`, `mem_w = 0`. Any in-flight external read is discarded.
- **Grant latency:**
  - Core: 0 cycles; the core path is combinational.
  - External on a free port: 0 cycles (ready in the same cycle as valid).
  - External worst case with the core busy every cycle: the handshake occurs in cycle `STARVE_LIMIT` after `ext_valid` rises, counting the first cycle as 0.
- **Read latency:** `ext_rvalid` goes high exactly 1 cycle after the read handshake.
- **Back-to-back reads:** external reads on consecutive cycles yield `ext_rvalid` on consecutive cycles.
- **Interleaving:** a core access in the cycle after an external read is legal; the memory pipelines both.
- **Counter/handshake collision:** a handshake in the same cycle the counter would hit the limit takes priority. The counter clears and no FORCE cycle follows.
- **`core_stall`:** high for exactly one cycle per FORCE and never two cycles in a row. At least `STARVE_LIMIT` IDLE cycles separate FORCE entries.

## Structure
- A shared package `mem_pkg` holds:
  - Size-select constants `MEM_SZ_B = 3'b000`, `MEM_SZ_H = 3'b001`, `MEM_SZ_W = 3'b010`, `MEM_SZ_BU = 3'b100`, `MEM_SZ_HU = 3'b101`.
  - FSM state encoding `ARB_IDLE` / `ARB_FORCE`.
- One sub-module, `starve_counter`: a parameterised saturating counter with clear input and a `hit` output.
- The mux and FSM stay in `dmem_arbiter`.

## Test plan
- **Reset mid-read:** `ext_valid=1`, `ext_w=0`, `ext_addr=0x40`, `core_req=0` → `ext_ready=1`. Asserting `rst` next cycle → `ext_rvalid=0` and `proto_err=0`.
- **Free-port write then read:** `ext_w=1`, `ext_addr=0x100`, `ext_wdata=0xDEADBEEF`, `core_req=0` → `mem_w=1` with those values that cycle. A following read of 0x100 → `ext_rvalid=1` and `ext_rdata=0xDEADBEEF` one cycle later.
- **Starvation:** `core_req=1` every cycle and `ext_valid=1` from cycle 0, `STARVE_LIMIT=8` → `core_stall=1` and `ext_ready=1` in cycle 8 only. Cycle 9 returns to core grant.
- **Counter/handshake collision:** `core_req` drops in cycle 7 of a starvation run → handshake in cycle 7, no FORCE in cycle 8, `starve_cnt=0`.
- **Protocol violation:** `core_req=1` during FORCE → `mem_addr` is `ext_addr`, the core access is dropped, `proto_err=1` and it stays 1 until `rst`.
- **Pipelined interleave:** external read at 0x20 in cycle N (core idle), core read at 0x24 in cycle N+1 → `ext_rvalid` in N+1 carries the 0x20 data, `ext_rvalid=0` in N+2, and `core_rdata` in N+2 is the 0x24 data.
